// File: rtl/cv32e40p_obi_mux.sv
// rtl/cv32e40p_obi_mux.sv - N-channel OBI request mux with channel-ID FIFO for response routing
// Option macro: CV32E40P_OBI_MUX_FIXED_PRIO_EN (lowest channel index always wins; no round-robin pointer)
module cv32e40p_obi_mux #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH-1:0]          ch_req_i,
    output logic [NUM_CH-1:0]          ch_gnt_o,
    output logic [NUM_CH-1:0]          ch_rvalid_o,
    input  logic [NUM_CH-1:0]          ch_we_i,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_be_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
    output logic [DATA_W-1:0]          ch_rdata_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_rvalid_i,
    output logic                       mem_we_o,
    output logic [DATA_W/8-1:0]        mem_be_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [SEL_W-1:0] arb_sel;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] lock_sel_q;
    logic             lock_q;
    logic [SEL_W-1:0] id_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [SEL_W-1:0] head_id;

`ifndef CV32E40P_OBI_MUX_FIXED_PRIO_EN
    logic [SEL_W-1:0]  rr_ptr_q;
    logic [NUM_CH-1:0] req_rot;
    logic              found;
    int                s;
`endif

    always_comb begin
        arb_sel = '0;
`ifdef CV32E40P_OBI_MUX_FIXED_PRIO_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req_i[i]) arb_sel = SEL_W'(i);
        end
`else
        // Rotate so bit 0 is the channel just after the last granted one
        req_rot = NUM_CH'({ch_req_i, ch_req_i} >> rr_ptr_q);
        found   = 1'b0;
        s       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                s     = int'(rr_ptr_q) + i;
                if (s >= NUM_CH) s = s - NUM_CH;
                arb_sel = SEL_W'(s);
            end
        end
`endif
    end

    // A pending, ungranted address phase keeps its channel regardless of new requests
    assign sel        = lock_q ? lock_sel_q : arb_sel;
    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign mem_req_o  = (|ch_req_i) & ~fifo_full & ~rst_i;
    assign push       = mem_req_o & mem_gnt_i;
    assign pop        = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign head_id    = id_mem_q[rd_ptr_q];
    assign ch_rdata_o = mem_rdata_i;
    assign err_o      = err_q;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        ch_gnt_o    = '0;
        ch_rvalid_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mem_req_o && sel == SEL_W'(i)) begin
                mem_we_o    = ch_we_i[i];
                mem_be_o    = ch_be_i[i*BE_W +: BE_W];
                mem_addr_o  = ch_addr_i[i*ADDR_W +: ADDR_W];
                mem_wdata_o = ch_wdata_i[i*DATA_W +: DATA_W];
            end
            ch_gnt_o[i]    = push & (sel == SEL_W'(i));
            ch_rvalid_o[i] = pop & (head_id == SEL_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            err_q      <= 1'b0;
`ifndef CV32E40P_OBI_MUX_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            if (push) begin
                id_mem_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
`ifndef CV32E40P_OBI_MUX_FIXED_PRIO_EN
                rr_ptr_q <= (sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
`endif
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            lock_q     <= mem_req_o & ~mem_gnt_i;
            lock_sel_q <= sel;
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_mux.sv
// tb/tb_cv32e40p_obi_mux.sv - scoreboard bench for cv32e40p_obi_mux (2 channels, depth 2)
module tb_cv32e40p_obi_mux;

`ifdef CV32E40P_OBI_MUX_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  ch_req_i;
    logic [1:0]  ch_gnt_o;
    logic [1:0]  ch_rvalid_o;
    logic [1:0]  ch_we_i;
    logic [7:0]  ch_be_i;
    logic [63:0] ch_addr_i;
    logic [63:0] ch_wdata_i;
    logic [31:0] ch_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    cv32e40p_obi_mux #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o), .ch_rvalid_o(ch_rvalid_o),
        .ch_we_i(ch_we_i), .ch_be_i(ch_be_i), .ch_addr_i(ch_addr_i),
        .ch_wdata_i(ch_wdata_i), .ch_rdata_o(ch_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } rsp_t;

    int   gnt_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t mon_r;
    int   mon_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input int ch);
        return (ch == 0) ? 32'h0000_1000 : 32'h0000_2000;
    endfunction

    function automatic logic [31:0] wdata_of(input int ch);
        return (ch == 0) ? 32'hD0D0_D0D0 : 32'hD1D1_D1D1;
    endfunction

    always @(negedge clk_i) begin
        if (mem_rvalid_i) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("rvalid_mask", 32'(ch_rvalid_o), (mon_r.ch < 0) ? 32'd0 : 32'(1 << mon_r.ch));
                if (mon_r.ch >= 0) chk("rdata", ch_rdata_o, mon_r.data);
            end
        end else begin
            chk("rvalid_idle", 32'(ch_rvalid_o), 32'd0);
        end
        if (mem_req_o && mem_gnt_i) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                mon_g = gnt_q.pop_front();
                chk("gnt_mask", 32'(ch_gnt_o), 32'(1 << mon_g));
                chk("gnt_addr", mem_addr_o, addr_of(mon_g));
                chk("gnt_wdata", mem_wdata_o, wdata_of(mon_g));
                chk("gnt_we", 32'(mem_we_o), (mon_g == 1) ? 32'd1 : 32'd0);
            end
        end else begin
            chk("gnt_idle", 32'(ch_gnt_o), 32'd0);
        end
    end

    task automatic drive(input logic r, input logic [1:0] req, input logic g,
                         input logic rv, input logic [31:0] rd);
        rst_i        = r;
        ch_req_i     = req;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    task automatic exp_rsp(input int ch, input logic [31:0] d);
        rsp_t r;
        r.ch   = ch;
        r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        ch_we_i    = 2'b10;
        ch_be_i    = {4'h3, 4'hF};
        ch_addr_i  = {32'h0000_2000, 32'h0000_1000};
        ch_wdata_i = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        next_cycle();

        // reset: everything forced quiet even with requests, grant and rvalid present
        drive(1'b1, 2'b11, 1'b1, 1'b1, 32'h0000_005A);
        exp_rsp(-1, 32'h0);
        #3;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        next_cycle();

        // contention: round-robin alternates, one response per cycle keeps count at 1
        drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
        gnt_q.push_back(0);
        #3;
        chk("rr_mem_req", 32'(mem_req_o), 32'd1);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h1111_0000);
        gnt_q.push_back(FP ? 0 : 1);
        exp_rsp(0, 32'h1111_0000);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h2222_0000);
        gnt_q.push_back(0);
        exp_rsp(FP ? 0 : 1, 32'h2222_0000);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h3333_0000);
        gnt_q.push_back(FP ? 0 : 1);
        exp_rsp(0, 32'h3333_0000);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h4444_0000);
        exp_rsp(FP ? 0 : 1, 32'h4444_0000);
        next_cycle();

        // lock: ch1 waits ungranted, ch0 arrives but must not steal the address phase
        drive(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
        #3;
        chk("lock_addr_c1", mem_addr_o, 32'h0000_2000);
        next_cycle();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 32'h0);
        #3;
        chk("lock_addr_c2", mem_addr_o, 32'h0000_2000);
        next_cycle();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 32'h0);
        #3;
        chk("lock_addr_c3", mem_addr_o, 32'h0000_2000);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
        gnt_q.push_back(1);
        next_cycle();
        drive(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
        gnt_q.push_back(0);
        next_cycle();

        // full FIFO: no request, and no bypass in the cycle a response pops
        drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
        #3;
        chk("full_mem_req", 32'(mem_req_o), 32'd0);
        chk("full_addr", mem_addr_o, 32'd0);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'hAAAA_5555);
        exp_rsp(1, 32'hAAAA_5555);
        #3;
        chk("full_no_bypass", 32'(mem_req_o), 32'd0);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h0000_1234);
        exp_rsp(0, 32'h0000_1234);
        gnt_q.push_back(FP ? 0 : 1);
        #3;
        chk("refill_mem_req", 32'(mem_req_o), 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_BEEF);
        exp_rsp(FP ? 0 : 1, 32'h0000_BEEF);
        next_cycle();

        // stray response sets the sticky error; only reset clears it
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_DEAD);
        exp_rsp(-1, 32'h0);
        #3;
        chk("err_before", 32'(err_o), 32'd0);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        #3;
        chk("err_set", 32'(err_o), 32'd1);
        next_cycle();
        #3;
        chk("err_held", 32'(err_o), 32'd1);
        next_cycle();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        #3;
        chk("err_cleared", 32'(err_o), 32'd0);
        next_cycle();
        next_cycle();

        chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
